// File: rtl/vga_bounce_ctrl.sv
// Bouncing-object position controller: moves an object one STEP per axis every
// FRAMES_PER_STEP enabled frame ticks, reversing at the 0 and MAX edges.
module vga_bounce_ctrl #(
  parameter int X_MAX           = 500,
  parameter int Y_MAX           = 440,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        restart,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        pos_valid,
  output logic        hit_x,
  output logic        hit_y,
  output logic [15:0] bounce_cnt
);

  typedef enum logic {DIR_INC, DIR_DEC} dir_t;

  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [7:0]  DIV_LAST = 8'(FRAMES_PER_STEP - 1);

  // Reset asserts immediately but releases only on a clock edge.
  logic [1:0] sync_reg;
  logic       rst_int_n;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b00;
    else        sync_reg <= {sync_reg[0], 1'b1};
  end

  assign rst_int_n = sync_reg[1];

  logic [7:0]  div_reg, div_next;
  logic        update;
  logic        pos_valid_reg;
  logic [15:0] bounce_reg, bounce_next;
  logic        any_hit;

  assign update = frame_tick && enable && !restart && (div_reg == DIV_LAST);

  always_comb begin
    div_next = div_reg;
    if (restart)
      div_next = 8'd0;
    else if (frame_tick && enable)
      div_next = (div_reg == DIV_LAST) ? 8'd0 : div_reg + 8'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic [10:0] AMAX = 11'((gi == 0) ? X_MAX : Y_MAX);

      dir_t       dir_reg, dir_next;
      logic [9:0] pos_reg, pos_next;
      logic       hit_reg, hit_next;
      logic [10:0] pos_ext;

      always_comb begin
        pos_ext  = {1'b0, pos_reg};
        pos_next = pos_reg;
        dir_next = dir_reg;
        hit_next = 1'b0;
        if (update) begin
          case (dir_reg)
            DIR_INC: begin
              if (pos_ext + STEP_W >= AMAX) begin
                pos_next = AMAX[9:0];
                dir_next = DIR_DEC;
                hit_next = 1'b1;
              end else begin
                pos_next = 10'(pos_ext + STEP_W);
              end
            end
            DIR_DEC: begin
              if (pos_ext <= STEP_W) begin
                pos_next = 10'd0;
                dir_next = DIR_INC;
                hit_next = 1'b1;
              end else begin
                pos_next = 10'(pos_ext - STEP_W);
              end
            end
            default: dir_next = DIR_INC;
          endcase
        end
      end

      always_ff @(posedge pclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
          dir_reg <= DIR_INC;
          pos_reg <= 10'd0;
          hit_reg <= 1'b0;
        end else if (restart) begin
          dir_reg <= DIR_INC;
          pos_reg <= 10'd0;
          hit_reg <= 1'b0;
        end else begin
          dir_reg <= dir_next;
          pos_reg <= pos_next;
          hit_reg <= hit_next;
        end
      end
    end
  endgenerate

  // A corner reversal on both axes still counts as a single bounce event.
  assign any_hit = g_axis[0].hit_next | g_axis[1].hit_next;

  always_comb begin
    bounce_next = bounce_reg;
    if (restart)
      bounce_next = 16'd0;
    else if (any_hit && bounce_reg != 16'hFFFF)
      bounce_next = bounce_reg + 16'd1;
  end

  always_ff @(posedge pclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      div_reg       <= 8'd0;
      pos_valid_reg <= 1'b0;
      bounce_reg    <= 16'd0;
    end else begin
      div_reg       <= div_next;
      pos_valid_reg <= update;
      bounce_reg    <= bounce_next;
    end
  end

  assign x_pos      = g_axis[0].pos_reg;
  assign y_pos      = g_axis[1].pos_reg;
  assign hit_x      = g_axis[0].hit_reg;
  assign hit_y      = g_axis[1].hit_reg;
  assign pos_valid  = pos_valid_reg;
  assign bounce_cnt = bounce_reg;

endmodule

// File: tb/tb_vga_bounce_ctrl.sv
// Scoreboard bench: four parameterisations share stimulus; expected updates are
// queued per instance and a negedge monitor checks each pos_valid pulse.
module tb_vga_bounce_ctrl;

  logic clk = 1'b0;
  logic rst_n, frame_tick, enable, restart;
  logic [9:0]  x_w   [4];
  logic [9:0]  y_w   [4];
  logic        pv_w  [4];
  logic        hx_w  [4];
  logic        hy_w  [4];
  logic [15:0] cnt_w [4];

  always #5 clk = ~clk;

  vga_bounce_ctrl dut_a (
    .pclk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .restart(restart),
    .x_pos(x_w[0]), .y_pos(y_w[0]), .pos_valid(pv_w[0]), .hit_x(hx_w[0]), .hit_y(hy_w[0]),
    .bounce_cnt(cnt_w[0]));

  vga_bounce_ctrl #(.STEP(3), .FRAMES_PER_STEP(4)) dut_b (
    .pclk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .restart(restart),
    .x_pos(x_w[1]), .y_pos(y_w[1]), .pos_valid(pv_w[1]), .hit_x(hx_w[1]), .hit_y(hy_w[1]),
    .bounce_cnt(cnt_w[1]));

  vga_bounce_ctrl #(.X_MAX(10), .Y_MAX(20), .STEP(4)) dut_c (
    .pclk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .restart(restart),
    .x_pos(x_w[2]), .y_pos(y_w[2]), .pos_valid(pv_w[2]), .hit_x(hx_w[2]), .hit_y(hy_w[2]),
    .bounce_cnt(cnt_w[2]));

  vga_bounce_ctrl #(.X_MAX(8), .Y_MAX(8), .STEP(2)) dut_d (
    .pclk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .restart(restart),
    .x_pos(x_w[3]), .y_pos(y_w[3]), .pos_valid(pv_w[3]), .hit_x(hx_w[3]), .hit_y(hy_w[3]),
    .bounce_cnt(cnt_w[3]));

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hx;
    logic        hy;
    logic [15:0] cnt;
  } exp_t;

  exp_t q [4][$];
  logic mon_en [4];
  int   n_pass  = 0;
  int   n_total = 0;

  // Hand-computed update sequences: C = (10,20,step 4), D = (8,8,step 2).
  int c_tab [8][5] = '{'{4,4,0,0,0}, '{8,8,0,0,0}, '{10,12,1,0,1}, '{6,16,0,0,1},
                       '{2,20,0,1,2}, '{0,16,1,0,3}, '{4,12,0,0,3}, '{8,8,0,0,3}};
  int d_tab [8][5] = '{'{2,2,0,0,0}, '{4,4,0,0,0}, '{6,6,0,0,0}, '{8,8,1,1,1},
                       '{6,6,0,0,1}, '{4,4,0,0,1}, '{2,2,0,0,1}, '{0,0,1,1,2}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%0d required=%0d", name, act, req);
    else             n_pass++;
  endtask

  task automatic push(input int i, input int x, input int y, input int hx, input int hy, input int cnt);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.hx = 1'(hx); e.hy = 1'(hy); e.cnt = 16'(cnt);
    q[i].push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(3);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mon_en[i] && pv_w[i]) begin
        if (q[i].size() == 0) begin
          chk($sformatf("dut%0d_unexpected_pos_valid", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q[i].pop_front();
          $display("dut%0d update: x=%0d y=%0d hx=%0d hy=%0d cnt=%0d", i,
                   x_w[i], y_w[i], hx_w[i], hy_w[i], cnt_w[i]);
          chk($sformatf("dut%0d_x", i),   32'(x_w[i]),   32'(e.x));
          chk($sformatf("dut%0d_y", i),   32'(y_w[i]),   32'(e.y));
          chk($sformatf("dut%0d_hx", i),  32'(hx_w[i]),  32'(e.hx));
          chk($sformatf("dut%0d_hy", i),  32'(hy_w[i]),  32'(e.hy));
          chk($sformatf("dut%0d_cnt", i), 32'(cnt_w[i]), 32'(e.cnt));
        end
      end else if (mon_en[i] && (hx_w[i] || hy_w[i])) begin
        chk($sformatf("dut%0d_stray_hit", i), 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) mon_en[i] = 1'b1;
    rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; restart = 1'b0;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_dut%0d_x", i),   32'(x_w[i]),   32'd0);
      chk($sformatf("rst_dut%0d_y", i),   32'(y_w[i]),   32'd0);
      chk($sformatf("rst_dut%0d_cnt", i), 32'(cnt_w[i]), 32'd0);
      chk($sformatf("rst_dut%0d_pv", i),  32'(pv_w[i]),  32'd0);
    end
    rst_n = 1'b1;
    cyc(4);
    enable = 1'b1;

    // Eight enabled ticks: per-tick motion, divided motion, edge and corner bounces.
    for (int k = 1; k <= 8; k++) begin
      push(0, k, k, 0, 0, 0);
      if (k % 4 == 0) push(1, 3 * (k / 4), 3 * (k / 4), 0, 0, 0);
      push(2, c_tab[k-1][0], c_tab[k-1][1], c_tab[k-1][2], c_tab[k-1][3], c_tab[k-1][4]);
      push(3, d_tab[k-1][0], d_tab[k-1][1], d_tab[k-1][2], d_tab[k-1][3], d_tab[k-1][4]);
      tick();
    end

    // Frozen: ticks must not move anything or reach the divider.
    enable = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("freeze_a_x",   32'(x_w[0]),   32'd8);
    chk("freeze_b_x",   32'(x_w[1]),   32'd6);
    chk("freeze_d_cnt", 32'(cnt_w[3]), 32'd2);

    // Restart beats a coincident enabled tick.
    enable = 1'b1;
    restart = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    restart = 1'b0;
    frame_tick = 1'b0;
    cyc(3);
    chk("restart_a_x",   32'(x_w[0]),   32'd0);
    chk("restart_a_y",   32'(y_w[0]),   32'd0);
    chk("restart_c_cnt", 32'(cnt_w[2]), 32'd0);
    chk("restart_d_cnt", 32'(cnt_w[3]), 32'd0);

    // Long run to x=37 on the default instance; C and D run unchecked here.
    mon_en[2] = 1'b0;
    mon_en[3] = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      push(0, k, k, 0, 0, 0);
      if (k % 4 == 0) push(1, 3 * (k / 4), 3 * (k / 4), 0, 0, 0);
      tick();
    end
    chk("run_a_x", 32'(x_w[0]), 32'd37);
    chk("run_d_cnt_nonzero", 32'(cnt_w[3] != 16'd0), 32'd1);

    // Asynchronous reset between clock edges.
    rst_n = 1'b0;
    #2;
    chk("async_a_x",   32'(x_w[0]),   32'd0);
    chk("async_a_y",   32'(y_w[0]),   32'd0);
    chk("async_b_x",   32'(x_w[1]),   32'd0);
    chk("async_d_cnt", 32'(cnt_w[3]), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);

    // First tick after reset: single-tick instances move, B's divider starts over.
    mon_en[2] = 1'b1;
    mon_en[3] = 1'b1;
    push(0, 1, 1, 0, 0, 0);
    push(2, 4, 4, 0, 0, 0);
    push(3, 2, 2, 0, 0, 0);
    tick();
    cyc(2);

    for (int i = 0; i < 4; i++)
      chk($sformatf("dut%0d_missing_updates", i), 32'(q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
